ipm_red_mask_loader: RTL and testbench

Serial IPM input-masking stage that sits directly upstream of the masked AES cipher core. It takes an unmasked 128-bit plaintext and the public IPM vector `L1`, and encodes each plaintext byte into `v` GF(2^8) shares using fresh randomness. It produces one byte per cycle over 16 cycles and presents the complete masked state in the `16*(v*8)`-bit layout the cipher core's `plaintext` port expects.

---
 rtl/ipm_red_mask_loader.sv | 133 +++++++++++++
 tb/tb_ipm_red_mask_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ipm_red_mask_loader.sv
// IPM input-masking stage: encodes each plaintext byte into v GF(2^8) shares,
// one byte per clock, and assembles the masked state for the cipher core.
//
// state | meaning
// IDLE  | waiting for start; masked output and out_valid hold
// RUN   | writing byte k's shares, k = 0..15
module ipm_red_mask_loader #(
    parameter int v = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [127:0]         plaintext,
    input  logic [v*8-1:0]       L1,
    input  logic [(v-1)*8-1:0]   rnd,
    output logic                 rnd_req,
    output logic [16*v*8-1:0]    masked_plaintext,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid
);

    localparam int SLOT_W = v * 8;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            k_q;
    logic [127:0]          pt_q;
    logic [(v-1)*8-1:0]    l1_q;
    logic [16*v*8-1:0]     mp_q, mp_d;
    logic                  done_q;
    logic                  out_valid_q;
    logic                  load, step, last;
    logic [7:0]            s_byte;
    logic [7:0]            r0;
    logic [SLOT_W-1:0]     slot;

    // L1 element 0 is fixed to 1 by construction, so its input bits are not stored.
    logic                  unused_l1_0;
    assign unused_l1_0 = ^L1[7:0];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (k_q == 4'd15) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Share 0 absorbs the secret so that <L1, R> with L1_0 = 1 equals S.
    always_comb begin
        s_byte = 8'h00;
        for (int b = 0; b < 16; b++) begin
            if (k_q == 4'(b)) s_byte = pt_q[b*8 +: 8];
        end
        r0 = s_byte;
        for (int j = 1; j < v; j++) begin
            r0 = r0 ^ gmul(l1_q[(j-1)*8 +: 8], rnd[(j-1)*8 +: 8]);
        end
        slot = {rnd, r0};
        mp_d = mp_q;
        for (int b = 0; b < 16; b++) begin
            if (k_q == 4'(b)) mp_d[b*SLOT_W +: SLOT_W] = slot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q         <= 4'd0;
            pt_q        <= '0;
            l1_q        <= '0;
            mp_q        <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            done_q <= last;
            if (load) begin
                pt_q        <= plaintext;
                l1_q        <= L1[v*8-1:8];
                mp_q        <= '0;
                out_valid_q <= 1'b0;
                k_q         <= 4'd0;
            end else if (step) begin
                mp_q <= mp_d;
                k_q  <= k_q + 4'd1;
            end
            if (last) out_valid_q <= 1'b1;
        end
    end

    assign busy             = (state_q == RUN);
    assign rnd_req          = busy;
    assign done             = done_q;
    assign out_valid        = out_valid_q;
    assign masked_plaintext = mp_q;

endmodule

// File: tb/tb_ipm_red_mask_loader.sv
// Directed and random checks for the IPM masking loader (v = 4).
module tb_ipm_red_mask_loader;

    localparam int V = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [127:0]   plaintext;
    logic [31:0]    L1;
    logic [23:0]    rnd;
    logic           rnd_req;
    logic [511:0]   masked_plaintext;
    logic           busy;
    logic           done;
    logic           out_valid;

    int             n_cmp = 0;
    int             n_err = 0;
    logic [23:0]    rnd_log [16];
    int             req_cnt;
    bit             done_early;
    bit             ov_seen;

    ipm_red_mask_loader #(.v(V)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .plaintext        (plaintext),
        .L1               (L1),
        .rnd              (rnd),
        .rnd_req          (rnd_req),
        .masked_plaintext (masked_plaintext),
        .busy             (busy),
        .done             (done),
        .out_valid        (out_valid)
    );

    always #5 clk = ~clk;

    // Reference multiply: carry-less product, then polynomial reduction by 0x11B.
    function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] unmask(input logic [31:0] s, input logic [31:0] l1v);
        return s[7:0] ^ gmul_ref(l1v[15:8], s[15:8]) ^ gmul_ref(l1v[23:16], s[23:16])
               ^ gmul_ref(l1v[31:24], s[31:24]);
    endfunction

    function automatic logic [511:0] model_mp(input logic [127:0] pt, input logic [31:0] l1v);
        logic [511:0] m;
        logic [7:0]   r0;
        m = '0;
        for (int k = 0; k < 16; k++) begin
            r0 = pt[8*k +: 8] ^ gmul_ref(l1v[15:8], rnd_log[k][7:0])
                 ^ gmul_ref(l1v[23:16], rnd_log[k][15:8]) ^ gmul_ref(l1v[31:24], rnd_log[k][23:16]);
            m[32*k +: 32] = {rnd_log[k], r0};
        end
        return m;
    endfunction

    // Starts a run and steps through E0..E16; returns just after E16.
    task automatic drive_run(input logic [127:0] pt, input logic [31:0] l1v,
                             input bit use_rand, input logic [23:0] fixed);
        plaintext = pt;
        L1        = l1v;
        start     = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        req_cnt    = 0;
        done_early = 1'b0;
        ov_seen    = 1'b0;
        for (int c = 0; c < 16; c++) begin
            rnd_log[c] = use_rand ? 24'($urandom) : fixed;
            rnd        = rnd_log[c];
            if (rnd_req)   req_cnt++;
            if (done)      done_early = 1'b1;
            if (out_valid) ov_seen = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; plaintext = '0; L1 = '0; rnd = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (rnd_req !== 1'b0) begin n_err++; $display("FAIL reset_rnd_req: got %b expected 0", rnd_req); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (masked_plaintext !== '0) begin n_err++; $display("FAIL reset_mp: got %h expected 0", masked_plaintext); end
        rst = 1'b0;
    endtask

    task automatic test_zero_rnd;
        logic [127:0] pt;
        logic [511:0] exp_mp;
        pt = 128'h00112233445566778899aabbccddeeff;
        for (int k = 0; k < 16; k++) exp_mp[32*k +: 32] = {24'h0, pt[8*k +: 8]};
        drive_run(pt, 32'h0A0B0C01, 1'b0, 24'h0);
        n_cmp++; if (done_early !== 1'b0) begin n_err++; $display("FAIL zero_done_early: got %b expected 0", done_early); end
        n_cmp++; if (ov_seen !== 1'b0) begin n_err++; $display("FAIL zero_ov_during_run: got %b expected 0", ov_seen); end
        n_cmp++; if (req_cnt !== 16) begin n_err++; $display("FAIL zero_rnd_req_cycles: got %0d expected 16", req_cnt); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done_at_e16: got %b expected 1", done); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zero_out_valid: got %b expected 1", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_after: got %b expected 0", busy); end
        n_cmp++; if (masked_plaintext !== exp_mp) begin n_err++; $display("FAIL zero_mp: got %h expected %h", masked_plaintext, exp_mp); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_fall: got %b expected 0", done); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zero_out_valid_hold: got %b expected 1", out_valid); end
        n_cmp++; if (masked_plaintext !== exp_mp) begin n_err++; $display("FAIL zero_mp_hold: got %h expected %h", masked_plaintext, exp_mp); end
    endtask

    task automatic test_known_product;
        logic [511:0] exp_mp;
        // byte 0: 0x53 ^ gmul(0x57,0x83)=0xC1 -> 0x92; other bytes: 0 ^ 0xC1
        for (int k = 1; k < 16; k++) exp_mp[32*k +: 32] = 32'h000083C1;
        exp_mp[31:0] = 32'h00008392;
        drive_run({120'h0, 8'h53}, 32'h00005701, 1'b0, 24'h000083);
        n_cmp++; if (masked_plaintext[31:0] !== 32'h00008392) begin n_err++; $display("FAIL known_byte0: got %h expected 00008392", masked_plaintext[31:0]); end
        n_cmp++; if (masked_plaintext !== exp_mp) begin n_err++; $display("FAIL known_mp: got %h expected %h", masked_plaintext, exp_mp); end
    endtask

    task automatic test_full_inner;
        logic [127:0] pt;
        pt = 128'h0123456789abcdeffedcba9876543253;
        drive_run(pt, 32'h04030201, 1'b0, 24'h010101);
        n_cmp++; if (masked_plaintext[31:0] !== 32'h01010156) begin n_err++; $display("FAIL inner_byte0: got %h expected 01010156", masked_plaintext[31:0]); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (unmask(masked_plaintext[32*k +: 32], 32'h04030201) !== pt[8*k +: 8]) begin
                n_err++;
                $display("FAIL inner_unmask byte %0d: got %h expected %h", k,
                         unmask(masked_plaintext[32*k +: 32], 32'h04030201), pt[8*k +: 8]);
            end
        end
    endtask

    task automatic test_regression;
        logic [127:0] pt;
        logic [31:0]  l1v;
        for (int run = 0; run < 1000; run++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            l1v = $urandom;
            drive_run(pt, l1v, 1'b1, 24'h0);
            n_cmp++; if (req_cnt !== 16) begin n_err++; $display("FAIL reg_rnd_req run %0d: got %0d expected 16", run, req_cnt); end
            n_cmp++; if (done !== 1'b1 || done_early !== 1'b0) begin n_err++; $display("FAIL reg_done run %0d: got %b/%b expected 1/0", run, done, done_early); end
            for (int k = 0; k < 16; k++) begin
                n_cmp++;
                if (unmask(masked_plaintext[32*k +: 32], l1v) !== pt[8*k +: 8]) begin
                    n_err++;
                    $display("FAIL reg_inner run %0d byte %0d: got %h expected %h", run, k,
                             unmask(masked_plaintext[32*k +: 32], l1v), pt[8*k +: 8]);
                end
                n_cmp++;
                if (masked_plaintext[32*k+8 +: 24] !== rnd_log[k]) begin
                    n_err++;
                    $display("FAIL reg_shares run %0d byte %0d: got %h expected %h", run, k,
                             masked_plaintext[32*k+8 +: 24], rnd_log[k]);
                end
            end
        end
    endtask

    // start held high and plaintext changed mid-run; runs repeat every 17 cycles.
    task automatic test_back_to_back;
        logic [127:0] pa, pb;
        logic [511:0] exp_a, exp_b;
        pa = 128'hdeadbeef_00010203_04050607_cafef00d;
        pb = 128'h11111111_22222222_33333333_44444444;
        for (int k = 0; k < 16; k++) begin
            exp_a[32*k +: 32] = {24'h0, pa[8*k +: 8]};
            exp_b[32*k +: 32] = {24'h0, pb[8*k +: 8]};
        end
        rnd = '0; L1 = 32'h9C5E3A01; plaintext = pa; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) plaintext = pb;
            @(posedge clk); #1;
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done1: got %b expected 1", done); end
        n_cmp++; if (masked_plaintext !== exp_a) begin n_err++; $display("FAIL b2b_mp1: got %h expected %h", masked_plaintext, exp_a); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart_busy: got %b expected 1", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_ov_drop: got %b expected 0", out_valid); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_fall: got %b expected 0", done); end
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
        end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_early: got %b expected 0", done); end
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done2: got %b expected 1", done); end
        n_cmp++; if (masked_plaintext !== exp_b) begin n_err++; $display("FAIL b2b_mp2: got %h expected %h", masked_plaintext, exp_b); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_run;
        logic [127:0] pt;
        bit           done_seen;
        pt = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        plaintext = pt; L1 = 32'h12345601; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            rnd = 24'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || rnd_req !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b/%b expected 0/0", busy, rnd_req); end
        n_cmp++; if (done !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_flags: got %b/%b expected 0/0", done, out_valid); end
        n_cmp++; if (masked_plaintext !== '0) begin n_err++; $display("FAIL rstmid_mp: got %h expected 0", masked_plaintext); end
        done_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done || busy) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (done_seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done: got %b expected 0", done_seen); end
        drive_run(pt, 32'h12345601, 1'b1, 24'h0);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rstmid_rerun_done: got %b expected 1", done); end
        n_cmp++; if (masked_plaintext !== model_mp(pt, 32'h12345601)) begin n_err++; $display("FAIL rstmid_rerun_mp: got %h expected %h", masked_plaintext, model_mp(pt, 32'h12345601)); end
    endtask

    initial begin
        test_reset;
        test_zero_rnd;
        test_known_product;
        test_full_inner;
        test_back_to_back;
        test_reset_mid_run;
        test_regression;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
